sr_flag_arbiter: RTL and testbench

- Shared bank of clocked SR flags, written by several requesters through a round-robin arbiter.
- Each requester issues a 2-bit SR command using the team's latch encoding: 00 hold, 01 reset, 10 set, 11 illegal. The command targets one flag index.
- The block serialises these commands, applies at most one per clock, and replaces level-sensitive SR latches with a synchronous, conflict-checked flag store.

---
 rtl/sr_flag_arbiter_if.sv | 14 +
 rtl/sr_flag_arbiter.sv | 128 ++++++++++++
 tb/tb_sr_flag_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sr_flag_arbiter_if.sv
// Requester-side handshake bundle for sr_flag_arbiter.
// Requesters drive req/sr/idx and receive a one-cycle gnt acknowledge.
interface sr_flag_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 3
);
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    sr;
  logic [IDXW*NREQ-1:0] idx;
  logic [NREQ-1:0]      gnt;

  modport master (output req, output sr, output idx, input gnt);
  modport slave  (input req, input sr, input idx, output gnt);
endinterface

// File: rtl/sr_flag_arbiter.sv
// Shared bank of clocked SR flags written by several requesters.
// A round-robin arbiter picks one command per clock; the chosen command
// sets, resets or leaves one flag. Illegal commands (sr=11 or an
// out-of-range index) leave the bank untouched and raise a sticky error.
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3,
  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  sr_flag_arbiter_if.slave bus,
  input  logic             err_clr,
  output logic [NFLAG-1:0] q,
  output logic [NFLAG-1:0] qb,
  output logic             err,
  output logic [PTRW-1:0]  err_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    CMD_HOLD  = 2'b00,
    CMD_RESET = 2'b01,
    CMD_SET   = 2'b10,
    CMD_ILL   = 2'b11
  } sr_cmd_e;

  // Registered state
  logic [PTRW-1:0]  ptr_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NFLAG-1:0] q_q;
  logic             err_q;
  logic [PTRW-1:0]  err_id_q;

  // Next-state values
  logic [PTRW-1:0]  ptr_d;
  logic [NREQ-1:0]  gnt_d;
  logic [NFLAG-1:0] q_d;
  logic             err_d;
  logic [PTRW-1:0]  err_id_d;

  // Arbitration helpers
  logic [NREQ-1:0]  elig;
  logic             found;
  logic [PTRW-1:0]  win;
  logic [PTRW-1:0]  cand;
  sr_cmd_e          cmd_sr;
  logic [IDXW-1:0]  cmd_idx;
  logic             illegal;

  // A requester acknowledged this cycle is masked so its held req is not reapplied.
  assign elig = bus.req & ~gnt_q;
  assign busy = |elig;

  // Round-robin search: first eligible requester at or after ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PTRW'((int'(ptr_q) + k) % NREQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Decode the winner's command and compute the next flag/error/pointer state.
  always_comb begin
    ptr_d    = ptr_q;
    gnt_d    = '0;
    q_d      = q_q;
    err_d    = err_q;
    err_id_d = err_id_q;
    cmd_sr   = sr_cmd_e'(bus.sr[2*win +: 2]);
    cmd_idx  = bus.idx[IDXW*win +: IDXW];
    illegal  = (cmd_sr == CMD_ILL) || (int'(cmd_idx) >= NFLAG);

    if (e) begin
      if (err_clr) err_d = 1'b0;
      if (found) begin
        gnt_d[win] = 1'b1;
        ptr_d      = (int'(win) == NREQ - 1) ? '0 : win + PTRW'(1);
        // An illegal command at the same edge as err_clr keeps the error set.
        if (illegal) begin
          err_d    = 1'b1;
          err_id_d = win;
        end else begin
          unique case (cmd_sr)
            CMD_RESET: q_d[cmd_idx] = 1'b0;
            CMD_SET:   q_d[cmd_idx] = 1'b1;
            default:   q_d = q_q;
          endcase
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      gnt_q    <= '0;
      // NOTE: the flag bank is a plain register vector, so it is reset along with the control state.
      q_q      <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      q_q      <= q_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  assign bus.gnt = gnt_q;
  assign q       = q_q;
  assign qb      = ~q_q;
  assign err     = err_q;
  assign err_id  = err_id_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: reset, single requester set/reset,
// round-robin order and wrap, error handling, enable freeze, mid-burst reset.
module tb_sr_flag_arbiter;
  logic       clk;
  logic       rst;
  logic       e;
  logic       err_clr;
  logic [7:0] q;
  logic [7:0] qb;
  logic       err;
  logic [1:0] err_id;
  logic       busy;

  int vec_count;
  int miscompares;

  sr_flag_arbiter_if #(.NREQ(4), .IDXW(3)) bus ();

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .e       (e),
    .bus     (bus),
    .err_clr (err_clr),
    .q       (q),
    .qb      (qb),
    .err     (err),
    .err_id  (err_id),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then move to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cmd(input int i, input logic [1:0] s, input logic [2:0] ix);
    bus.sr[2*i +: 2]  = s;
    bus.idx[3*i +: 3] = ix;
  endtask

  task automatic test_reset();
    rst = 1'b1; e = 1'b0; err_clr = 1'b0;
    bus.req = '0; bus.sr = '0; bus.idx = '0;
    step();
    step();
    rst = 1'b0;
    vec_count++;
    if (q !== 8'h00) begin miscompares++; $display("FAIL reset_q: got %h want 00", q); end
    vec_count++;
    if (qb !== 8'hFF) begin miscompares++; $display("FAIL reset_qb: got %h want ff", qb); end
    vec_count++;
    if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    vec_count++;
    if (err !== 1'b0 || err_id !== 2'd0) begin
      miscompares++; $display("FAIL reset_err: got err=%b id=%0d want err=0 id=0", err, err_id);
    end
    vec_count++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_set_reset();
    e = 1'b1;
    bus.req = 4'b0001;
    set_cmd(0, 2'b10, 3'd3);
    step();
    vec_count++;
    if (q !== 8'h08 || bus.gnt !== 4'b0001) begin
      miscompares++; $display("FAIL single_set: got q=%h gnt=%b want q=08 gnt=0001", q, bus.gnt);
    end
    vec_count++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL single_masked_busy: got %b want 0", busy); end
    step();
    vec_count++;
    if (bus.gnt !== 4'b0000 || q !== 8'h08) begin
      miscompares++; $display("FAIL single_no_double: got q=%h gnt=%b want q=08 gnt=0000", q, bus.gnt);
    end
    step();
    vec_count++;
    if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL single_regrant: got %b want 0001", bus.gnt); end
    set_cmd(0, 2'b01, 3'd3);
    step();
    step();
    vec_count++;
    if (q !== 8'h00 || qb !== 8'hFF || bus.gnt !== 4'b0001) begin
      miscompares++; $display("FAIL single_reset: got q=%h qb=%h gnt=%b want q=00 qb=ff gnt=0001", q, qb, bus.gnt);
    end
    bus.req = '0;
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [7:0] exp_q [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F};
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_cmd(i, 2'b10, 3'(i));
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      vec_count++;
      if (bus.gnt !== exp_g[i] || q !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rr_grant_%0d: got gnt=%b q=%h want gnt=%b q=%h", i, bus.gnt, q, exp_g[i], exp_q[i]);
      end
    end
    bus.req = '0;
    step();
  endtask

  task automatic test_error();
    // ptr is 1 here after the round-robin wrap.
    bus.req = 4'b0100;
    set_cmd(2, 2'b11, 3'd5);
    step();
    vec_count++;
    if (bus.gnt !== 4'b0100 || q !== 8'h0F || err !== 1'b1 || err_id !== 2'd2) begin
      miscompares++;
      $display("FAIL err_set: got gnt=%b q=%h err=%b id=%0d want 0100 0f 1 2", bus.gnt, q, err, err_id);
    end
    bus.req = 4'b0010;
    set_cmd(1, 2'b11, 3'd1);
    err_clr = 1'b1;
    step();
    vec_count++;
    if (bus.gnt !== 4'b0010 || err !== 1'b1 || err_id !== 2'd1 || q !== 8'h0F) begin
      miscompares++;
      $display("FAIL err_clr_vs_ill: got gnt=%b err=%b id=%0d q=%h want 0010 1 1 0f", bus.gnt, err, err_id, q);
    end
    bus.req = '0;
    step();
    err_clr = 1'b0;
    vec_count++;
    if (err !== 1'b0 || err_id !== 2'd1) begin
      miscompares++; $display("FAIL err_clear: got err=%b id=%0d want err=0 id=1", err, err_id);
    end
  endtask

  task automatic test_enable_freeze();
    // ptr is 2 here; all requesters set flags 4..7.
    e = 1'b0;
    for (int i = 0; i < 4; i++) set_cmd(i, 2'b10, 3'(i + 4));
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      vec_count++;
      if (bus.gnt !== 4'b0000 || q !== 8'h0F || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL freeze_%0d: got gnt=%b q=%h busy=%b want 0000 0f 1", i, bus.gnt, q, busy);
      end
    end
    e = 1'b1;
    step();
    vec_count++;
    if (bus.gnt !== 4'b0100 || q !== 8'h4F) begin
      miscompares++; $display("FAIL resume_1: got gnt=%b q=%h want 0100 4f", bus.gnt, q);
    end
    step();
    vec_count++;
    if (bus.gnt !== 4'b1000 || q !== 8'hCF) begin
      miscompares++; $display("FAIL resume_2: got gnt=%b q=%h want 1000 cf", bus.gnt, q);
    end
    bus.req = '0;
    step();
  endtask

  task automatic test_reset_midburst();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 4'b0001;
    set_cmd(0, 2'b10, 3'd0);
    step();
    bus.req = 4'b0100;
    set_cmd(2, 2'b10, 3'd2);
    step();
    vec_count++;
    if (q !== 8'h05) begin miscompares++; $display("FAIL burst_setup: got q=%h want 05", q); end
    // ptr is 3 now; without the reset requester 3 would win next.
    bus.req = 4'b1011;
    set_cmd(0, 2'b10, 3'd7);
    set_cmd(1, 2'b10, 3'd6);
    set_cmd(3, 2'b10, 3'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    vec_count++;
    if (q !== 8'h00 || qb !== 8'hFF || bus.gnt !== 4'b0000) begin
      miscompares++; $display("FAIL burst_reset: got q=%h qb=%h gnt=%b want 00 ff 0000", q, qb, bus.gnt);
    end
    step();
    vec_count++;
    if (bus.gnt !== 4'b0001 || q !== 8'h80) begin
      miscompares++; $display("FAIL burst_first: got gnt=%b q=%h want 0001 80", bus.gnt, q);
    end
    step();
    vec_count++;
    if (bus.gnt !== 4'b0010 || q !== 8'hC0) begin
      miscompares++; $display("FAIL burst_second: got gnt=%b q=%h want 0010 c0", bus.gnt, q);
    end
    bus.req = '0;
    step();
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;
    test_reset();
    test_single_set_reset();
    test_round_robin();
    test_error();
    test_enable_freeze();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule
